// File: rtl/ecall_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ecall_unit
//  Purpose  : Environment-call responder for the single-cycle core. Services
//             print-int (a7=1), read-int (a7=5) and exit (a7=10); any other
//             service number is acknowledged with no side effect. Read-int
//             waits for a debounced release followed by a debounced press of
//             the confirm button before returning the switch value.
//
//  Ports    : clk          system clock, rising edge
//             reset        synchronous active-high reset
//             ecall_req    level request from the core (held until ack seen)
//             a7, a0       service number / argument, valid with ecall_req
//             sw           board switches
//             btn_confirm  confirm button, already synchronised to clk
//             ecall_ack    one-cycle completion pulse
//             stall        freeze PC and register writes
//             wb_en        write wb_data into a0 (asserted with ecall_ack)
//             wb_data      read-int result, held until the next read
//             disp_val     latched value for the display driver
//             halted       program has exited
//
//  Revision : 1.0  initial release
// ============================================================================
module ecall_unit #(
  parameter int DEBOUNCE  = 16,
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ecall_req,
  input  logic [31:0] a7,
  input  logic [31:0] a0,
  input  logic [15:0] sw,
  input  logic        btn_confirm,
  output logic        ecall_ack,
  output logic        stall,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic [31:0] disp_val,
  output logic        halted
);

  localparam int CW = $clog2(DEBOUNCE) + 1;

  localparam logic [CW-1:0] c_cnt_last  = CW'(DEBOUNCE - 1);
  localparam logic [31:0]   c_svc_print = 32'd1;
  localparam logic [31:0]   c_svc_read  = 32'd5;
  localparam logic [31:0]   c_svc_exit  = 32'd10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_REL   = 3'd1,
    ST_WAIT_PRESS = 3'd2,
    ST_ACK        = 3'd3,
    ST_HALT       = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic          r_ack;
  logic          w_ack_nx;
  logic          r_wb_en;
  logic          w_wb_en_nx;
  logic [31:0]   r_wb_data;
  logic [31:0]   w_wb_data_nx;
  logic [31:0]   r_disp;
  logic [31:0]   w_disp_nx;
  logic [31:0]   w_sw_ext;

  // Switch value widened to a register-file word.
  assign w_sw_ext = SIGNED_IN ? {{16{sw[15]}}, sw} : {16'h0000, sw};

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_data <= '0;
      r_disp    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_ack     <= w_ack_nx;
      r_wb_en   <= w_wb_en_nx;
      r_wb_data <= w_wb_data_nx;
      r_disp    <= w_disp_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_ack_nx     = 1'b0;   // ack and write-enable are single-cycle pulses
    w_wb_en_nx   = 1'b0;
    w_wb_data_nx = r_wb_data;
    w_disp_nx    = r_disp;

    case (r_state)
      ST_IDLE: begin
        if (ecall_req) begin
          // The service is captured here; later a7/a0 changes are ignored
          // because the waiting states never look at them.
          if (a7 == c_svc_print) begin
            w_disp_nx  = a0;
            w_ack_nx   = 1'b1;
            w_state_nx = ST_ACK;
          end else if (a7 == c_svc_read) begin
            w_cnt_nx   = '0;
            w_state_nx = ST_WAIT_REL;
          end else if (a7 == c_svc_exit) begin
            w_state_nx = ST_HALT;
          end else begin
            w_ack_nx   = 1'b1;
            w_state_nx = ST_ACK;
          end
        end
      end

      // Require a stable release first so a button still held from the
      // previous read cannot confirm this one.
      ST_WAIT_REL: begin
        if (btn_confirm) begin
          w_cnt_nx = '0;
        end else if (r_cnt >= c_cnt_last) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_WAIT_PRESS;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end

      ST_WAIT_PRESS: begin
        if (!btn_confirm) begin
          w_cnt_nx = '0;
        end else if (r_cnt >= c_cnt_last) begin
          w_cnt_nx     = '0;
          w_wb_data_nx = w_sw_ext;
          w_wb_en_nx   = 1'b1;
          w_ack_nx     = 1'b1;
          w_state_nx   = ST_ACK;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end

      // One cycle with ack visible, then back to IDLE. The core drops its
      // request during this cycle, so IDLE never sees a stale request.
      ST_ACK: begin
        w_state_nx = ST_IDLE;
      end

      ST_HALT: begin
        w_state_nx = ST_HALT;
      end

      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ecall_ack = r_ack;
  assign wb_en     = r_wb_en;
  assign wb_data   = r_wb_data;
  assign disp_val  = r_disp;
  assign halted    = (r_state == ST_HALT);
  // Combinational so the core freezes in the very cycle the request appears.
  assign stall     = (ecall_req & ~r_ack) | halted;

endmodule
`default_nettype wire

// File: tb/tb_ecall_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ecall_unit
//  Purpose  : Self-checking bench for ecall_unit. Two instances (signed and
//             unsigned read-int) share stimulus. Expected read timing is
//             derived from the button sample history: the first window of
//             DEBOUNCE lows after dispatch, then the first window of DEBOUNCE
//             highs after that.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ecall_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ecall_req;
  logic [31:0] a7;
  logic [31:0] a0;
  logic [15:0] sw;
  logic        btn_confirm;

  logic        ecall_ack,   stall,   wb_en,   halted;
  logic [31:0] wb_data,   disp_val;
  logic        ecall_ack_u, stall_u, wb_en_u, halted_u;
  logic [31:0] wb_data_u, disp_val_u;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_disp;
  logic [31:0] exp_wb_s;
  logic [31:0] exp_wb_u;

  bit          btn_q[$];
  logic [15:0] sw_hist[$];

  always #5 clk = ~clk;

  ecall_unit #(.DEBOUNCE(D), .SIGNED_IN(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .ecall_req(ecall_req), .a7(a7), .a0(a0),
    .sw(sw), .btn_confirm(btn_confirm), .ecall_ack(ecall_ack), .stall(stall),
    .wb_en(wb_en), .wb_data(wb_data), .disp_val(disp_val), .halted(halted)
  );

  ecall_unit #(.DEBOUNCE(D), .SIGNED_IN(1'b0)) u_dut_u (
    .clk(clk), .reset(reset), .ecall_req(ecall_req), .a7(a7), .a0(a0),
    .sw(sw), .btn_confirm(btn_confirm), .ecall_ack(ecall_ack_u), .stall(stall_u),
    .wb_en(wb_en_u), .wb_data(wb_data_u), .disp_val(disp_val_u), .halted(halted_u)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  task automatic do_reset();
    ecall_req   = 1'b0;
    btn_confirm = 1'b0;
    reset       = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    exp_disp = 32'h0;
    exp_wb_s = 32'h0;
    exp_wb_u = 32'h0;
    check_eq("rst_ack",    32'(ecall_ack), 32'd0);
    check_eq("rst_wb_en",  32'(wb_en),     32'd0);
    check_eq("rst_wb",     wb_data,        32'h0);
    check_eq("rst_disp",   disp_val,       32'h0);
    check_eq("rst_halted", 32'(halted),    32'd0);
    check_eq("rst_stall",  32'(stall),     32'd0);
  endtask

  // Print or any non-read, non-exit service.
  task automatic do_simple(input logic [31:0] a7v, input logic [31:0] a0v);
    ecall_req = 1'b1;
    a7 = a7v;
    a0 = a0v;
    sw = 16'($urandom);
    #1;
    check_eq("req_stall", 32'(stall),     32'd1);
    check_eq("req_ack",   32'(ecall_ack), 32'd0);
    next_cycle();
    if (a7v == 32'd1) exp_disp = a0v;
    a7 = $urandom;
    a0 = $urandom;
    #1;
    check_eq("simple_ack",   32'(ecall_ack),   32'd1);
    check_eq("simple_wb_en", 32'(wb_en),       32'd0);
    check_eq("simple_disp",  disp_val,         exp_disp);
    check_eq("simple_disp_u", disp_val_u,      exp_disp);
    check_eq("simple_wb",    wb_data,          exp_wb_s);
    check_eq("simple_stall", 32'(stall),       32'd0);
    next_cycle();
    ecall_req = 1'b0;
    #1;
    check_eq("simple_ack_drop", 32'(ecall_ack), 32'd0);
    check_eq("simple_idle_stall", 32'(stall),   32'd0);
  endtask

  // Read-int using the button samples in btn_q (index 0 = request cycle).
  task automatic do_read(input bit use_fix, input logic [15:0] swv);
    int  j;
    int  m;
    bit  ok;
    j = -1;
    m = -1;
    for (int k = D; k < btn_q.size(); k++) begin
      ok = 1'b1;
      for (int i = k - D + 1; i <= k; i++) if (btn_q[i]) ok = 1'b0;
      if (ok) begin j = k; break; end
    end
    if (j >= 0) begin
      for (int k = j + D; k < btn_q.size(); k++) begin
        ok = 1'b1;
        for (int i = k - D + 1; i <= k; i++) if (!btn_q[i]) ok = 1'b0;
        if (ok) begin m = k; break; end
      end
    end
    if (m < 0) begin
      check_eq("model_seq", 32'd0, 32'd1);
      return;
    end
    sw_hist.delete();
    for (int k = 0; k <= m + 1; k++) begin
      ecall_req   = 1'b1;
      a7          = (k == 0) ? 32'd5 : $urandom;
      a0          = $urandom;
      btn_confirm = (k < btn_q.size()) ? btn_q[k] : 1'b1;
      sw          = use_fix ? swv : 16'($urandom);
      sw_hist.push_back(sw);
      #1;
      if (k <= m) begin
        check_eq("read_ack_early", 32'(ecall_ack), 32'd0);
        check_eq("read_stall",     32'(stall),     32'd1);
      end else begin
        exp_wb_s = sext16(sw_hist[m]);
        exp_wb_u = zext16(sw_hist[m]);
        check_eq("read_ack",     32'(ecall_ack),   32'd1);
        check_eq("read_ack_u",   32'(ecall_ack_u), 32'd1);
        check_eq("read_wb_en",   32'(wb_en),       32'd1);
        check_eq("read_wb_en_u", 32'(wb_en_u),     32'd1);
        check_eq("read_wb_s",    wb_data,          exp_wb_s);
        check_eq("read_wb_u",    wb_data_u,        exp_wb_u);
        check_eq("read_disp",    disp_val,         exp_disp);
        check_eq("read_stall_ack", 32'(stall),     32'd0);
      end
      next_cycle();
    end
    ecall_req = 1'b0;
    #1;
    check_eq("read_ack_drop", 32'(ecall_ack), 32'd0);
    check_eq("read_wb_en_drop", 32'(wb_en),   32'd0);
    check_eq("read_wb_hold",  wb_data,        exp_wb_s);
  endtask

  task automatic rand_btn_seq();
    bit lvl;
    int len;
    btn_q.delete();
    btn_q.push_back(1'($urandom_range(0, 1)));
    for (int r = 0; r < int'($urandom_range(0, 5)); r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, D + 1);
      for (int i = 0; i < len; i++) btn_q.push_back(lvl);
    end
    for (int i = 0; i < D; i++) btn_q.push_back(1'b0);
    for (int i = 0; i < D; i++) btn_q.push_back(1'b1);
  endtask

  task automatic do_exit();
    ecall_req = 1'b1;
    a7 = 32'd10;
    a0 = $urandom;
    #1;
    check_eq("exit_req_stall", 32'(stall), 32'd1);
    next_cycle();
    #1;
    check_eq("exit_halted", 32'(halted),    32'd1);
    check_eq("exit_ack",    32'(ecall_ack), 32'd0);
    check_eq("exit_stall",  32'(stall),     32'd1);
    ecall_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_confirm = 1'($urandom_range(0, 1));
      next_cycle();
    end
    #1;
    check_eq("halt_hold",     32'(halted),    32'd1);
    check_eq("halt_hold_u",   32'(halted_u),  32'd1);
    check_eq("halt_stall",    32'(stall),     32'd1);
    check_eq("halt_stall_u",  32'(stall_u),   32'd1);
    check_eq("halt_no_ack",   32'(ecall_ack), 32'd0);
    check_eq("halt_disp",     disp_val,       exp_disp);
    do_reset();
  endtask

  initial begin
    int sel;
    reset       = 1'b1;
    ecall_req   = 1'b0;
    a7          = 32'h0;
    a0          = 32'h0;
    sw          = 16'h0;
    btn_confirm = 1'b0;
    next_cycle();
    do_reset();

    // Print after reset.
    do_simple(32'd1, 32'hDEADBEEF);

    // Read with button held at request: release 4, press 4.
    btn_q = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_read(1'b1, 16'h8001);
    check_eq("dir_wb_s", wb_data,   32'hFFFF8001);
    check_eq("dir_wb_u", wb_data_u, 32'h00008001);

    // Bounce inside WAIT_PRESS: 3 high, 1 low, then 4 high.
    btn_q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
             1'b1, 1'b1, 1'b1, 1'b1};
    do_read(1'b0, 16'h0);

    // Unknown service.
    do_simple(32'd7, 32'h12345678);

    // Exit then print after reset.
    do_exit();
    do_simple(32'd1, 32'hCAFEF00D);

    // Reset in WAIT_PRESS with the counter at 2.
    ecall_req   = 1'b1;
    a7          = 32'd5;
    btn_confirm = 1'b1;
    next_cycle();
    for (int i = 0; i < D; i++) begin
      btn_confirm = 1'b0;
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      btn_confirm = 1'b1;
      #1;
      check_eq("pre_rst_no_ack", 32'(ecall_ack), 32'd0);
      next_cycle();
    end
    do_reset();
    btn_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b1, 1'b1, 1'b1, 1'b1};
    do_read(1'b0, 16'h0);

    // Randomised transactions.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        ecall_req   = 1'b0;
        btn_confirm = 1'($urandom_range(0, 1));
        next_cycle();
        check_eq("gap_ack", 32'(ecall_ack), 32'd0);
      end
      sel = $urandom_range(0, 9);
      if (sel <= 2)      do_simple(32'd1, $urandom);
      else if (sel <= 5) begin rand_btn_seq(); do_read(1'b0, 16'h0); end
      else if (sel == 6) do_exit();
      else if (sel == 7) do_simple(32'd7, $urandom);
      else if (sel == 8) do_simple($urandom | 32'h100, $urandom);
      else               do_simple(32'h0001_0001, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ecall_unit.md
# ecall_unit

Environment-call responder for the single-cycle core. When the decode stage sees the `ecall` encoding (32'h00000073), the core raises a request carrying the current a7 (service number) and a0 (argument). The core then stalls until this block completes the service and acknowledges. This block drives the board-side I/O: the display latch, switch input and confirm button. It returns the read value that the register file writes back into a0.

## Interface
- `DEBOUNCE`, default 16: consecutive stable cycles required to accept a button level. Minimum 1.
- `SIGNED_IN`, default 0: 1 means read-int sign-extends `sw[15:0]`; 0 means it zero-extends.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `ecall_req`  in  1  level request. Held high by the core from ecall decode until the cycle `ecall_ack` is seen.
- `a7`  in  32  service number; valid while `ecall_req` is high.
- `a0`  in  32  service argument; valid while `ecall_req` is high.
- `sw`  in  16  board switches.
- `btn_confirm`  in  1  confirm button, raw (bouncy). Synchronised externally to `clk`.
- `ecall_ack`  out  1  one-cycle completion pulse.
- `stall`  out  1  freeze PC and register writes while high.
- `wb_en`  out  1  high with `ecall_ack` when `wb_data` must be written to a0.
- `wb_data`  out  32  value for a0.
- `disp_val`  out  32  latched value for the seven-segment/LED driver.
- `halted`  out  1  program has exited.

## Operation
- States: IDLE, WAIT_REL, WAIT_PRESS, ACK, HALT.
- Services, decoded from the full 32-bit `a7`:
  - 1 (print int): `disp_val` <= `a0`, then ACK.
  - 5 (read int): WAIT_REL, then WAIT_PRESS, then ACK with write-back.
  - 10 (exit): HALT.
  - Any other value: ACK with no side effect.
- IDLE with `ecall_req`=1: on that edge, latch the service and dispatch as above. For services 1 and "other", `ecall_ack` <= 1 and state <= ACK on the same edge.
- WAIT_REL: counter `cnt` increments while `btn_confirm`=0 and clears to 0 when it is 1. When `cnt` reaches DEBOUNCE-1 with the button still low, clear `cnt` and go to WAIT_PRESS. This stops a button held from a previous read from auto-confirming.
- WAIT_PRESS: counter increments while `btn_confirm`=1 and clears when it is 0. On reaching DEBOUNCE-1 with the button high, the same edge does all of:
  - `wb_data` <= the extended `sw` value, sampled on that edge;
  - `wb_en` <= 1 and `ecall_ack` <= 1;
  - state <= ACK.
- ACK: outputs stay high for exactly one cycle. Next edge: `ecall_ack`, `wb_en` <= 0, state <= IDLE. `wb_data` holds its value until the next read.
- HALT: `halted`=1 and `stall`=1, with no `ecall_ack`. Leaves only on `reset`.
- `stall` = `ecall_req` & ~`ecall_ack`, or state==HALT. It is combinational, so the core freezes in the same cycle the request appears.
- `cnt` width: $clog2(DEBOUNCE)+1. It saturates and never wraps.

## Timing
- Reset applies on the edge where `reset`=1 and overrides every other event on that edge, including mid-WAIT, ACK and HALT.
- Values after reset: state IDLE, `cnt` 0, `ecall_ack` 0, `wb_en` 0, `wb_data` 0, `disp_val` 0, `halted` 0. `stall` follows `ecall_req`.
- Print and unknown services: request seen in cycle N, `ecall_ack` high in cycle N+1. `disp_val` updates visibly in cycle N+1.
- Read int: at least 2*DEBOUNCE+1 cycles from request to ack, with a clean button. Any bounce restarts the counter of the current wait state.
- The core drops `ecall_req` in the cycle after the ack. IDLE never sees a stale request, because ACK always spends one cycle returning to IDLE.
- `a7`/`a0` changes while in WAIT states are ignored; the service is latched at dispatch.

## Test plan
- Reset, then print: `a7`=1, `a0`=32'hDEADBEEF, `ecall_req`=1.
  - Next cycle: `ecall_ack`=1, `disp_val`=32'hDEADBEEF, `wb_en`=0.
  - `stall` is 1 in the request cycle and 0 in the ack cycle.
- Read int, DEBOUNCE=4, SIGNED_IN=1, `sw`=16'h8001, button held high at request.
  - No ack while the button is held.
  - Release for 4 cycles, then press for 4 cycles: `ecall_ack`=`wb_en`=1 with `wb_data`=32'hFFFF8001.
  - With SIGNED_IN=0 the same stimulus gives 32'h00008001.
- Bounce: while in WAIT_PRESS, press for 3 cycles, release for 1, then press for 4.
  - Ack arrives only after the second run completes, i.e. 4 cycles after the re-press.
- Exit: `a7`=10.
  - `halted`=1 and `stall`=1 indefinitely, even after `ecall_req` drops.
  - `reset`=1 for one edge clears `halted`, and the block accepts a following print.
- Unknown service `a7`=7: ack the next cycle; `disp_val` and `wb_data` unchanged, `wb_en`=0.
- Reset during WAIT_PRESS with the counter at 2:
  - State returns to IDLE with no ack.
  - A subsequent read requires the full release-then-press sequence.
